// File: rtl/traffic_light_fsm.sv
// Main/side street light sequencer with a walk phase, timed by a tick-driven interval counter.
// Outputs are a Moore decode of the state register; WR_Reset is a registered entry pulse.
module traffic_light_fsm #(
    parameter int unsigned BASE_TICKS = 6,
    parameter int unsigned EXT_TICKS  = 3,
    parameter int unsigned YEL_TICKS  = 2,
    parameter int unsigned WALK_TICKS = 3,
    parameter int unsigned CW         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       sensor,
    input  logic       WR,
    output logic [2:0] main_lts,
    output logic [2:0] side_lts,
    output logic       walk,
    output logic       WR_Reset,
    output logic [2:0] state
);

    localparam logic [2:0] MG1 = 3'd0;
    localparam logic [2:0] MG2 = 3'd1;
    localparam logic [2:0] MY  = 3'd2;
    localparam logic [2:0] WLK = 3'd3;
    localparam logic [2:0] SG1 = 3'd4;
    localparam logic [2:0] SG2 = 3'd5;
    localparam logic [2:0] SY  = 3'd6;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Counter load values: a state lasting N ticks starts at N-1 and expires on the tick at 0.
    localparam logic [CW-1:0] BASE_LD = CW'(BASE_TICKS - 1);
    localparam logic [CW-1:0] EXT_LD  = CW'(EXT_TICKS - 1);
    localparam logic [CW-1:0] YEL_LD  = CW'(YEL_TICKS - 1);
    localparam logic [CW-1:0] WALK_LD = CW'(WALK_TICKS - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_reset_q, wr_reset_d;
    logic          expired;

    assign expired = tick && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q > SY) begin
            state_d = MG1;
            cnt_d   = BASE_LD;
        end else if (tick && !expired) begin
            cnt_d = cnt_q - 1'b1;
        end else if (expired) begin
            case (state_q)
                MG1: begin
                    state_d = MG2;
                    cnt_d   = sensor ? EXT_LD : BASE_LD;
                end
                MG2: begin
                    state_d = MY;
                    cnt_d   = YEL_LD;
                end
                MY: begin
                    if (WR) begin
                        state_d = WLK;
                        cnt_d   = WALK_LD;
                    end else begin
                        state_d = SG1;
                        cnt_d   = BASE_LD;
                    end
                end
                WLK: begin
                    state_d = SG1;
                    cnt_d   = BASE_LD;
                end
                SG1: begin
                    if (sensor) begin
                        state_d = SG2;
                        cnt_d   = EXT_LD;
                    end else begin
                        state_d = SY;
                        cnt_d   = YEL_LD;
                    end
                end
                SG2: begin
                    state_d = SY;
                    cnt_d   = YEL_LD;
                end
                default: begin
                    state_d = MG1;
                    cnt_d   = BASE_LD;
                end
            endcase
        end
    end

    // Pulse only on the edge that enters WLK, so it covers exactly the first walk clock.
    assign wr_reset_d = (state_d == WLK) && (state_q != WLK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= MG1;
            cnt_q      <= BASE_LD;
            wr_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_reset_q <= wr_reset_d;
        end
    end

    always_comb begin
        main_lts = LAMP_R;
        side_lts = LAMP_R;
        walk     = 1'b0;
        case (state_q)
            MG1, MG2: main_lts = LAMP_G;
            MY:       main_lts = LAMP_Y;
            WLK:      walk     = 1'b1;
            SG1, SG2: side_lts = LAMP_G;
            SY:       side_lts = LAMP_Y;
            default: begin
                main_lts = LAMP_R;
                side_lts = LAMP_R;
            end
        endcase
    end

    assign WR_Reset = wr_reset_q;
    assign state    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: phase/ticks-remaining reference model compared every clock,
// plus literal phase-duration checks for the directed scenarios.
module tb_traffic_light_fsm;

    localparam int BASE  = 6;
    localparam int EXT   = 3;
    localparam int YEL   = 2;
    localparam int WALKT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       sensor = 1'b0;
    logic       WR = 1'b0;
    logic [2:0] main_lts, side_lts, state;
    logic       walk, WR_Reset;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase number plus ticks still to run in that phase.
    int m_phase = 0;
    int m_left  = BASE;
    bit m_wrr   = 1'b0;
    bit check_en = 1'b0;

    logic [2:0] exp_main [8];
    logic [2:0] exp_side [8];

    int trace[$];
    bit rec = 1'b0;
    int exp_st [8];
    int exp_ln [8];

    always #5 clock = ~clock;

    traffic_light_fsm #(
        .BASE_TICKS(BASE),
        .EXT_TICKS (EXT),
        .YEL_TICKS (YEL),
        .WALK_TICKS(WALKT),
        .CW        (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .sensor  (sensor),
        .WR      (WR),
        .main_lts(main_lts),
        .side_lts(side_lts),
        .walk    (walk),
        .WR_Reset(WR_Reset),
        .state   (state)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs that the coming edge will sample.
    task automatic model_step();
        bit entered_walk;
        entered_walk = 1'b0;
        if (reset || m_phase == 7) begin
            m_phase = 0;
            m_left  = BASE;
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                case (m_phase)
                    0: begin m_phase = 1; m_left = sensor ? EXT : BASE; end
                    1: begin m_phase = 2; m_left = YEL; end
                    2: if (WR) begin m_phase = 3; m_left = WALKT; end
                       else begin m_phase = 4; m_left = BASE; end
                    3: begin m_phase = 4; m_left = BASE; end
                    4: if (sensor) begin m_phase = 5; m_left = EXT; end
                       else begin m_phase = 6; m_left = YEL; end
                    5: begin m_phase = 6; m_left = YEL; end
                    default: begin m_phase = 0; m_left = BASE; end
                endcase
                entered_walk = (m_phase == 3);
            end
        end
        m_wrr = entered_walk;
    endtask

    // Drive one clock's inputs just after a negedge, then return on the following negedge.
    task automatic cycle(input bit r, input bit t, input bit s, input bit w);
        #1;
        reset  = r;
        tick   = t;
        sensor = s;
        WR     = w;
        model_step();
        @(negedge clock);
        if (rec) trace.push_back(int'(state));
    endtask

    task automatic do_reset();
        rec = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        trace.delete();
        rec = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_runs(string name, int n);
        int idx;
        int run;
        idx = 0;
        run = 1;
        for (int i = 1; i <= trace.size(); i++) begin
            if (i == trace.size() || trace[i] != trace[i-1]) begin
                if (idx < n) begin
                    check({name, " state"}, trace[i-1], exp_st[idx]);
                    check({name, " len"}, run, exp_ln[idx]);
                end
                idx++;
                run = 1;
            end else begin
                run++;
            end
        end
        if (idx < n) check({name, " runs"}, idx, n);
        rec = 1'b0;
    endtask

    task automatic check_reset_outputs(string name);
        check({name, " state"}, state, 0);
        check({name, " main"}, main_lts, 3'b001);
        check({name, " side"}, side_lts, 3'b100);
        check({name, " walk"}, walk, 0);
        check({name, " wr_reset"}, WR_Reset, 0);
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("state", state, m_phase);
            check("main_lts", main_lts, exp_main[m_phase]);
            check("side_lts", side_lts, exp_side[m_phase]);
            check("walk", walk, (m_phase == 3) ? 1 : 0);
            check("wr_reset", WR_Reset, m_wrr);
            check("both_heads_open", (main_lts != 3'b100) && (side_lts != 3'b100), 0);
        end
    end

    initial begin
        int walk_cnt;
        int wrr_cnt;
        bit wr_req;
        bit found;

        exp_main = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        exp_side = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100};

        // Case 1: default cycle, no sensor, no walk request.
        do_reset();
        check_en = 1'b1;
        check_reset_outputs("reset");
        for (int k = 0; k < 43; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        exp_st = '{0, 1, 2, 4, 6, 0, 0, 0};
        exp_ln = '{6, 6, 2, 6, 2, 0, 0, 0};
        check_runs("case1", 5);

        // Case 2: sensor held high extends both greens.
        do_reset();
        for (int k = 0; k < 23; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        exp_st = '{0, 1, 2, 4, 5, 6, 0, 0};
        exp_ln = '{6, 3, 2, 6, 3, 2, 0, 0};
        check_runs("case2", 6);

        // Case 2b: sensor only ever high away from the expiry cycles.
        do_reset();
        for (int k = 0; k < 43; k++) cycle(1'b0, 1'b1, (m_left != 1) ? 1'($urandom_range(1)) : 1'b0,
                                           1'b0);
        exp_st = '{0, 1, 2, 4, 6, 0, 0, 0};
        exp_ln = '{6, 6, 2, 6, 2, 0, 0, 0};
        check_runs("case2b", 5);

        // Case 3: walk request held until cleared.
        do_reset();
        walk_cnt = 0;
        wrr_cnt  = 0;
        wr_req   = 1'b1;
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 1'b1, 1'b0, wr_req);
            if (walk === 1'b1) walk_cnt++;
            if (WR_Reset === 1'b1) begin
                wrr_cnt++;
                wr_req = 1'b0;
            end
        end
        exp_st = '{0, 1, 2, 3, 4, 6, 0, 0};
        exp_ln = '{6, 6, 2, 3, 6, 2, 0, 0};
        check_runs("case3", 6);
        check("case3 walk clocks", walk_cnt, 3);
        check("case3 wr_reset pulses", wrr_cnt, 1);

        // Case 4: tick every 5th clock stretches every interval by five.
        do_reset();
        for (int k = 0; k < 115; k++) cycle(1'b0, (k % 5) == 0, 1'b0, 1'b0);
        exp_st = '{0, 1, 2, 4, 6, 0, 0, 0};
        exp_ln = '{26, 30, 10, 30, 10, 0, 0, 0};
        check_runs("case4", 5);

        // Case 5a: reset in the middle of SG1.
        do_reset();
        rec = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            found = (m_phase == 4 && m_left == 3);
        end
        check("case5a reached SG1", found, 1);
        trace.delete();
        rec = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check_reset_outputs("case5a");
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        exp_st = '{0, 1, 0, 0, 0, 0, 0, 0};
        exp_ln = '{6, 3, 0, 0, 0, 0, 0, 0};
        check_runs("case5a", 2);

        // Case 5b: reset on the same edge as the MY expiry tick, with WR high.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            found = (m_phase == 2 && m_left == 1);
        end
        check("case5b reached MY", found, 1);
        trace.delete();
        rec = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check_reset_outputs("case5b");
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_runs("case5b", 2);

        // Case 6: illegal code recovers, then random soak.
        #1;
        force dut.state_q = 3'd7;
        #1;
        release dut.state_q;
        m_phase = 7;
        cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        check("case6 recover", state, 0);
        for (int k = 0; k < 10000; k++) begin
            cycle(($urandom_range(255) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
